// File: rtl/virgule_pkg.sv
// Shared types for the virgule core: machine word, bus payloads, fetch entries and fetch FSM states.
package virgule_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    logic              valid;
    word_t             address;
    logic [STRB_W-1:0] wstrobe;
  } bus_req_t;

  typedef struct packed {
    logic  ready;
    word_t rdata;
  } bus_rsp_t;

  typedef struct packed {
    word_t pc;
    word_t data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_REQ_DISCARD
  } fetch_state_t;

  // Clear the byte offset of an address.
  function automatic word_t align_word(input word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with synchronous clear; head is read from storage registers.
module fetch_fifo
  import virgule_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) store[wr_ptr] <= wdata;
  end

  assign head = store[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word reads into a prefetch FIFO, flushed and restarted on redirect.
module fetch_unit
  import virgule_pkg::*;
#(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_wstrobe,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_data
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CAW = CW + 1;

  fetch_state_t   state;
  fetch_state_t   state_d;
  word_t          fetch_pc;
  word_t          fetch_pc_d;
  bus_req_t       req_q;
  bus_req_t       req_d;
  bus_rsp_t       rsp;
  fetch_entry_t   push_entry;
  fetch_entry_t   head;
  logic [CW-1:0]  count;
  logic [CAW-1:0] count_after;
  logic           push;
  logic           pop;
  logic           slot_free;

  assign rsp        = '{ready: mem_ready, rdata: mem_rdata};
  assign push_entry = '{pc: fetch_pc, data: rsp.rdata};

  // A completion is kept only in REQ and only when no redirect flushes it.
  always_comb begin
    pop         = out_valid && out_ready;
    push        = (state == FETCH_REQ) && rsp.ready && !redirect_valid;
    count_after = redirect_valid ? '0 : CAW'(count) + CAW'(push) - CAW'(pop);
    slot_free   = count_after < CAW'(DEPTH);
  end

  always_comb begin
    state_d         = state;
    fetch_pc_d      = fetch_pc;
    req_d           = req_q;
    req_d.wstrobe   = '0;

    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
    end else if (push) begin
      fetch_pc_d = fetch_pc + 32'd4;
    end

    case (state)
      FETCH_IDLE: begin
        if (slot_free) begin
          state_d       = FETCH_REQ;
          req_d.valid   = 1'b1;
          req_d.address = fetch_pc_d;
        end
      end
      FETCH_REQ: begin
        if (rsp.ready) begin
          if (slot_free) begin
            state_d       = FETCH_REQ;
            req_d.valid   = 1'b1;
            req_d.address = fetch_pc_d;
          end else begin
            state_d     = FETCH_IDLE;
            req_d.valid = 1'b0;
          end
        end else if (redirect_valid) begin
          // Request must stay on the bus; its data is dropped when it completes.
          state_d = FETCH_REQ_DISCARD;
        end
      end
      FETCH_REQ_DISCARD: begin
        if (rsp.ready) begin
          state_d     = FETCH_IDLE;
          req_d.valid = 1'b0;
        end
      end
      default: begin
        state_d     = FETCH_IDLE;
        req_d.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_q    <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (push_entry),
    .count (count),
    .head  (head)
  );

  assign mem_valid   = req_q.valid;
  assign mem_address = req_q.address;
  assign mem_wstrobe = req_q.wstrobe;
  assign out_valid   = (count != '0);
  assign out_pc      = head.pc;
  assign out_data    = head.data;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a stream-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_wstrobe;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;
  int wait_states = 0;
  bit force_ready = 0;

  fetch_unit #(
    .RESET_PC(RST),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_address   (mem_address),
    .mem_rdata     (mem_rdata),
    .mem_wstrobe   (mem_wstrobe),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_data      (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory: answers each request after wait_states idle cycles; force_ready injects one spurious completion.
  initial begin
    int wc;
    wc = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ready) begin
        mem_ready   = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        force_ready = 0;
        wc          = 0;
      end else if (mem_valid && !reset) begin
        if (wc >= wait_states) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_address);
          wc        = 0;
        end else begin
          mem_ready = 1'b0;
          wc++;
        end
      end else begin
        mem_ready = 1'b0;
        wc        = 0;
      end
    end
  end

  // Reference model: the expected instruction stream is the sequence of accepted fetch addresses.
  logic [63:0] mq[$];
  logic [31:0] exp_fetch;
  logic [31:0] pend_addr;
  bit          stale;
  bit          pend;

  always @(posedge clk) begin
    #3;
    if (reset) begin
      mq.delete();
      exp_fetch = RST;
      stale     = 0;
      pend      = 0;
    end else begin
      checks++;
      if (out_valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL mon_out_valid: got %b expected %b", out_valid, mq.size() != 0);
      end
      if (out_valid === 1'b1 && mq.size() != 0) begin
        checks++;
        if ({out_pc, out_data} !== mq[0]) begin
          errors++;
          $display("FAIL mon_head: got pc=%h data=%h expected pc=%h data=%h",
                   out_pc, out_data, mq[0][63:32], mq[0][31:0]);
        end
      end
      checks++;
      if (mem_wstrobe !== 4'b0000) begin
        errors++;
        $display("FAIL mon_wstrobe: got %b expected 0000", mem_wstrobe);
      end
      if (pend) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_address !== pend_addr) begin
          errors++;
          $display("FAIL mon_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                   mem_valid, mem_address, pend_addr);
        end
      end
      if (mem_valid && mem_ready && !stale) begin
        checks++;
        if (mem_address !== exp_fetch) begin
          errors++;
          $display("FAIL mon_fetch_addr: got %h expected %h", mem_address, exp_fetch);
        end
      end
      pend      = mem_valid && !mem_ready;
      pend_addr = mem_address;
      if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
        if (mem_valid) stale = !mem_ready;
      end else if (mem_valid && mem_ready) begin
        if (stale) begin
          stale = 0;
        end else begin
          mq.push_back({exp_fetch, mem_word(exp_fetch)});
          exp_fetch = exp_fetch + 32'd4;
          checks++;
          if (mq.size() > DEPTH) begin
            errors++;
            $display("FAIL mon_occupancy: got %0d expected <= %0d", mq.size(), DEPTH);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic apply_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mem_valid !== 1'b0 || out_valid !== 1'b0 || mem_wstrobe !== 4'b0000) begin
        errors++;
        $display("FAIL reset_state: got valid=%b out_valid=%b wstrobe=%b expected 0 0 0000",
                 mem_valid, out_valid, mem_wstrobe);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_address !== RST) begin
      errors++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 %h", mem_valid, mem_address, RST);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (i < 3) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_address !== RST + 32'(4 * i)) begin
          errors++;
          $display("FAIL seq_addr%0d: got %h expected %h", i, mem_address, RST + 32'(4 * i));
        end
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RST + 32'(4 * (i - 1)) ||
            out_data !== mem_word(RST + 32'(4 * (i - 1)))) begin
          errors++;
          $display("FAIL seq_out%0d: got pc=%h data=%h expected pc=%h", i, out_pc, out_data,
                   RST + 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    wait_states = 0;
    out_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      if (mem_valid && mem_ready) n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL bp_completions: got %0d expected %0d", n, DEPTH);
    end
    checks++;
    if (mem_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== RST) begin
      errors++;
      $display("FAIL bp_stalled: got valid=%b out_valid=%b pc=%h expected 0 1 %h",
               mem_valid, out_valid, out_pc, RST);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RST + 32'd4 || mem_valid !== 1'b1 || mem_address !== RST + 32'd8) begin
      errors++;
      $display("FAIL bp_resume: got pc=%h addr=%h valid=%b expected pc=%h addr=%h valid=1",
               out_pc, mem_address, mem_valid, RST + 32'd4, RST + 32'd8);
    end
  endtask

  task automatic test_wait_redirect();
    bit seen;
    wait_states = 3;
    out_ready = 1'b1;
    apply_reset();
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_waiting: got valid=%b ready=%b expected 1 0", mem_valid, mem_ready);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_address !== RST) begin
        errors++;
        $display("FAIL wr_hold%0d: got valid=%b addr=%h expected 1 %h", i, mem_valid, mem_address, RST);
      end
      if (i == 0) step();
    end
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_complete: got ready=%b expected 1", mem_ready);
    end
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (mem_valid) seen = 1;
      else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL wr_no_stale_out: got out_valid=%b pc=%h expected 0", out_valid, out_pc);
        end
      end
    end
    checks++;
    if (!seen || mem_address !== 32'h0000_0200) begin
      errors++;
      $display("FAIL wr_next_req: got seen=%b addr=%h expected 1 00000200", seen, mem_address);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen || out_pc !== 32'h0000_0200 || out_data !== mem_word(32'h0000_0200)) begin
      errors++;
      $display("FAIL wr_first_out: got seen=%b pc=%h expected 1 00000200", seen, out_pc);
    end
  endtask

  task automatic test_redirect_collision();
    wait_states = 0;
    out_ready = 1'b1;
    apply_reset();
    step();
    checks++;
    if (out_valid !== 1'b1 || mem_valid !== 1'b1 || mem_ready !== 1'b1 || out_pc !== RST) begin
      errors++;
      $display("FAIL col_setup: got out_valid=%b valid=%b ready=%b pc=%h expected 1 1 1 %h",
               out_valid, mem_valid, mem_ready, out_pc, RST);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mem_valid !== 1'b1 || mem_address !== 32'h0000_0200) begin
      errors++;
      $display("FAIL col_flush: got out_valid=%b valid=%b addr=%h expected 0 1 00000200",
               out_valid, mem_valid, mem_address);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0200) begin
      errors++;
      $display("FAIL col_restart_out: got out_valid=%b pc=%h expected 1 00000200", out_valid, out_pc);
    end
  endtask

  task automatic test_boundary();
    wait_states = 0;
    out_ready = 1'b1;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h0000_0200) begin
      errors++;
      $display("FAIL bnd_align: got valid=%b addr=%h expected 1 00000200", mem_valid, mem_address);
    end
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (mem_address !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL bnd_top: got addr=%h expected fffffffc", mem_address);
    end
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h0000_0000) begin
      errors++;
      $display("FAIL bnd_wrap: got valid=%b addr=%h expected 1 00000000", mem_valid, mem_address);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_data !== mem_word(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL bnd_wrap_out: got out_valid=%b pc=%h expected 1 fffffffc", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    wait_states = 3;
    out_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (mem_valid !== 1'b1 || mem_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_setup: got valid=%b ready=%b out_valid=%b expected 1 0 1",
               mem_valid, mem_ready, out_valid);
    end
    reset = 1'b1;
    force_ready = 1;
    step();
    checks++;
    if (mem_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_cleared: got valid=%b out_valid=%b expected 0 0", mem_valid, out_valid);
    end
    reset = 1'b0;
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_address !== RST) begin
      errors++;
      $display("FAIL rm_first_req: got valid=%b addr=%h expected 1 %h", mem_valid, mem_address, RST);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen || out_pc !== RST || out_data !== mem_word(RST)) begin
      errors++;
      $display("FAIL rm_first_out: got seen=%b pc=%h data=%h expected 1 %h %h",
               seen, out_pc, out_data, RST, mem_word(RST));
    end
  endtask

  task automatic test_random();
    int n_out;
    n_out = 0;
    wait_states = 0;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (out_valid && out_ready) n_out++;
      step();
      redirect_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) wait_states = $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
      end
    end
    step();
    redirect_valid = 1'b0;
    checks++;
    if (n_out == 0) begin
      errors++;
      $display("FAIL rnd_progress: got %0d transfers expected > 0", n_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_wait_redirect();
    test_redirect_collision();
    test_boundary();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
